// File: rtl/mux_arb_n.sv
// ============================================================================
// mux_arb_n : registered N-way W-bit mux with valid/ready on every channel,
//             direct-select or round-robin grant, one-entry output register.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_arb_n #(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_chan;
  logic             r_valid;
  logic [SEL_W-1:0] r_rr_last;

  logic             w_load_en;
  logic             w_dir_valid;
  logic             w_rr_valid;
  logic [SEL_W-1:0] w_rr_gnt;
  logic             w_gnt_valid;
  logic [SEL_W-1:0] w_gnt;
  logic [WIDTH-1:0] w_gnt_data;

  assign w_load_en = !r_valid || out_ready;

  // Out-of-range sel simply never matches a channel index, so it yields no grant.
  always_comb begin
    w_dir_valid = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_W'(i) && in_valid[i]) w_dir_valid = 1'b1;
    end
  end

  // Search starts one past the last winner and wraps modulo CHANNELS.
  always_comb begin
    w_rr_valid = 1'b0;
    w_rr_gnt   = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      if (!w_rr_valid && in_valid[(int'(r_rr_last) + k) % CHANNELS]) begin
        w_rr_valid = 1'b1;
        w_rr_gnt   = SEL_W'((int'(r_rr_last) + k) % CHANNELS);
      end
    end
  end

  always_comb begin
    w_gnt_valid = mode ? w_rr_valid : w_dir_valid;
    w_gnt       = mode ? w_rr_gnt   : sel;
  end

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_gnt == SEL_W'(i)) w_gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Gated by rst_n so no channel is accepted while reset is being held.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = rst_n && w_load_en && w_gnt_valid && (w_gnt == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_chan    <= '0;
      r_rr_last <= SEL_W'(CHANNELS - 1);
    end else if (w_load_en) begin
      if (w_gnt_valid) begin
        r_valid <= 1'b1;
        r_data  <= w_gnt_data;
        r_chan  <= w_gnt;
        if (mode) r_rr_last <= w_gnt;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux_arb_n.sv
// ============================================================================
// tb_mux_arb_n : directed bench for mux_arb_n (8-channel and 6-channel builds).
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_arb_n;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  // 8-channel instance
  logic         rst_n;
  logic [127:0] in_data;
  logic [7:0]   in_valid;
  logic [7:0]   in_ready;
  logic         mode;
  logic [2:0]   sel;
  logic [15:0]  out_data;
  logic [2:0]   out_chan;
  logic         out_valid;
  logic         out_ready;

  // 6-channel instance
  logic         b_rst_n;
  logic [95:0]  b_in_data;
  logic [5:0]   b_in_valid;
  logic [5:0]   b_in_ready;
  logic         b_mode;
  logic [2:0]   b_sel;
  logic [15:0]  b_out_data;
  logic [2:0]   b_out_chan;
  logic         b_out_valid;
  logic         b_out_ready;

  int total  = 0;
  int passed = 0;

  mux_arb_n #(.WIDTH(16), .CHANNELS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_arb_n #(.WIDTH(16), .CHANNELS(6)) dut6 (
    .clk(clk), .rst_n(b_rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .mode(b_mode), .sel(b_sel), .out_data(b_out_data),
    .out_chan(b_out_chan), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic fill8(input logic [15:0] base);
    for (int i = 0; i < 8; i++) in_data[i*16 +: 16] = base + 16'(i);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] d, input logic [2:0] c);
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, ".data"},  {16'd0, out_data},  {16'd0, d});
    check({tag, ".chan"},  {29'd0, out_chan},  {29'd0, c});
  endtask

  initial begin
    int exp_seq [6] = '{0, 1, 4, 7, 0, 1};

    // ---- reset with every channel valid ----
    rst_n = 1'b0; mode = 1'b1; sel = 3'd0; out_ready = 1'b1;
    in_valid = 8'hFF; fill8(16'h1000);
    b_rst_n = 1'b0; b_mode = 1'b0; b_sel = 3'd0; b_out_ready = 1'b1;
    b_in_valid = 6'h00;
    for (int i = 0; i < 6; i++) b_in_data[i*16 +: 16] = 16'h3000 + 16'(i);
    settle();
    check("rst.ready0", {24'd0, in_ready}, 32'h0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk_out("rst", 1'b0, 16'h0000, 3'd0);
      check("rst.ready", {24'd0, in_ready}, 32'h0);
    end

    // ---- first grant after release in round-robin is channel 0 ----
    rst_n = 1'b1; settle();
    check("rel.ready", {24'd0, in_ready}, 32'h01);
    tick();
    chk_out("rel", 1'b1, 16'h1000, 3'd0);

    // ---- mode 0 streaming on channel 5 ----
    mode = 1'b0; sel = 3'd5; in_valid = 8'b0010_0000; in_data[80 +: 16] = 16'h1234;
    settle();
    check("m0.ready1", {24'd0, in_ready}, 32'h20);
    tick();
    chk_out("m0.w1", 1'b1, 16'h1234, 3'd5);
    in_data[80 +: 16] = 16'hBEEF; settle();
    check("m0.ready2", {24'd0, in_ready}, 32'h20);
    tick();
    chk_out("m0.w2", 1'b1, 16'hBEEF, 3'd5);
    in_valid = 8'h00; settle();
    check("m0.idle_ready", {24'd0, in_ready}, 32'h0);
    tick();
    chk_out("m0.drain", 1'b0, 16'hBEEF, 3'd5);

    // ---- fresh rotation: round-robin fairness over 8'b1001_0011 ----
    rst_n = 1'b0; tick();
    rst_n = 1'b1; mode = 1'b1; in_valid = 8'b1001_0011; fill8(16'h2000);
    for (int n = 0; n < 6; n++) begin
      tick();
      chk_out($sformatf("rr%0d", n), 1'b1, 16'h2000 + 16'(exp_seq[n]), 3'(exp_seq[n]));
    end

    // ---- backpressure: hold channel 1 word for 3 cycles ----
    out_ready = 1'b0; settle();
    check("bp.ready0", {24'd0, in_ready}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out($sformatf("bp%0d", c), 1'b1, 16'h2001, 3'd1);
      check("bp.ready", {24'd0, in_ready}, 32'h0);
    end
    out_ready = 1'b1; settle();
    check("bp.release_ready", {24'd0, in_ready}, 32'h10);
    tick();
    chk_out("bp.next", 1'b1, 16'h2004, 3'd4);

    // ---- reset while a word is stalled ----
    out_ready = 1'b0; rst_n = 1'b0; settle();
    check("mrst.ready", {24'd0, in_ready}, 32'h0);
    tick();
    chk_out("mrst", 1'b0, 16'h0000, 3'd0);
    rst_n = 1'b1; in_valid = 8'h00; out_ready = 1'b1;
    tick();
    chk_out("mrst.lost", 1'b0, 16'h0000, 3'd0);

    // ---- 6-channel: out-of-range sel and mode switch with rr_last=2 ----
    b_rst_n = 1'b1; b_mode = 1'b0; b_sel = 3'd2; b_in_valid = 6'h3F;
    tick();
    check("b.sel2.chan", {29'd0, b_out_chan}, 32'd2);
    check("b.sel2.valid", {31'd0, b_out_valid}, 32'd1);
    b_sel = 3'd7; settle();
    check("b.sel7.ready", {26'd0, b_in_ready}, 32'h0);
    tick();
    check("b.sel7.valid", {31'd0, b_out_valid}, 32'd0);
    check("b.sel7.chan_hold", {29'd0, b_out_chan}, 32'd2);
    b_mode = 1'b1; b_in_valid = 6'b00_0100; settle();
    check("b.rr2.ready", {26'd0, b_in_ready}, 32'h04);
    tick();
    check("b.rr2.chan", {29'd0, b_out_chan}, 32'd2);
    b_mode = 1'b0; b_in_valid = 6'h3F; tick();
    check("b.drop.valid", {31'd0, b_out_valid}, 32'd0);
    b_mode = 1'b1; settle();
    check("b.rr3.ready", {26'd0, b_in_ready}, 32'h08);
    tick();
    check("b.rr3.chan", {29'd0, b_out_chan}, 32'd3);
    check("b.rr3.data", {16'd0, b_out_data}, 32'h3003);
    check("b.rr3.valid", {31'd0, b_out_valid}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- Parametrised, registered N-way W-bit multiplexer with valid/ready handshakes on every input channel and on the output.
- Two modes: direct select (sel picks the source) and round-robin arbitration across requesting channels.
- One-entry output register gives one-cycle latency and full throughput.
- Next-generation channel selector for datapath and bus-sharing paths where sources must be stalled rather than sampled blindly.

Parameters:
- WIDTH, 16, data width per channel.
- CHANNELS, 8, number of input channels (2..32).
- SEL_W, $clog2(CHANNELS), channel index width (derived, never overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_data  input  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel data valid
- in_ready  output  CHANNELS  per-channel accept; one-hot or zero
- mode  input  1  0 = direct select, 1 = round-robin
- sel  input  SEL_W  channel index used in mode 0
- out_data  output  WIDTH  registered selected word
- out_chan  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  out_data/out_chan valid
- out_ready  input  1  downstream accept

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_chan=0, rr_last=CHANNELS-1. While held in reset, in_ready=0. A held, undelivered word is discarded.
- Load enable: load_en = !out_valid | out_ready. Back-to-back transfers give one word per cycle.
- Grant is computed combinationally each cycle from the current mode, sel, in_valid and rr_last.
  - Mode 0: grant = sel if sel < CHANNELS and in_valid[sel]=1; otherwise no grant.
  - Mode 1: grant = the first i with in_valid[i]=1, searching rr_last+1, rr_last+2, … modulo CHANNELS. If no channel is valid, no grant.
- in_ready[i] = load_en & grant_valid & (grant == i). in_ready never depends on in_valid of other channels except through the grant.
- Transfer on channel i when in_valid[i] & in_ready[i]. At that edge:
  - out_data <= channel i data
  - out_chan <= i
  - out_valid <= 1
  - in mode 1 only, rr_last <= i
- If load_en=1 with no grant: out_valid <= 0, and out_data/out_chan hold their last values.
- Stall (out_valid=1, out_ready=0): out_data, out_chan and out_valid are held stable; all in_ready=0.
- Latency: input accepted at edge k appears on out_* after edge k (one cycle).
- Mode switch takes effect on the next grant computation. A word already in the output register is unaffected. rr_last is not modified in mode 0, so returning to mode 1 resumes the prior rotation.
- Wrap-around: after rr_last=CHANNELS-1 the search starts at 0.
- Out-of-range sel (possible when CHANNELS is not a power of 2): no grant, no error flag.
- Inputs may change freely while in_ready=0. The block holds no per-input state other than rr_last.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0 throughout; first grant after release in mode 1 is channel 0.
- Mode 0 streaming: WIDTH=16, CHANNELS=8, sel=5, ch5 = 0x1234 then 0xBEEF valid on consecutive cycles, out_ready=1 -> out_data 0x1234 then 0xBEEF on consecutive cycles, out_chan=5, in_ready=8'b0010_0000 each cycle.
- Round-robin fairness: mode=1, in_valid=8'b1001_0011 held, out_ready=1 -> out_chan sequence 0,1,4,7,0,1, one per cycle.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_data unchanged, in_ready=0. out_ready=1 -> held word taken and next word loaded the same cycle.
- Boundary: CHANNELS=6, mode 0, sel=7, all valid -> no grant, out_valid drops to 0. Mode switched to 1 mid-stream with rr_last=2 -> next grant is channel 3.
- Reset mid-operation: rst_n=0 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, and the held word is never delivered.
